mx_block_quant_ctrl: RTL

MX_BLOCK_QUANT_CTRL -- requirements
Module: mx_block_quant_ctrl

---
 rtl/mx_block_quant_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mx_block_quant_ctrl.sv
// mx_block_quant_ctrl
// Collects block_size signed elements and finds the widest one. It then emits
// every element rounded (round-half-to-even) to width_o bits, using a shift
// shared by the whole block. That shift is the smallest one that lets the
// widest element fit in width_o bits.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_data   : signed input element (width_i)
//   i_valid  : i_data valid
//   o_ready  : block buffer can accept an element (high only while filling)
//   o_data   : signed rounded element (width_o)
//   o_shift  : shared right-shift of the block being emitted
//   o_valid  : o_data/o_shift valid
//   o_last   : final element of the block
//   i_ready  : downstream accepts the output
module mx_block_quant_ctrl #(
    parameter int width_i     = 16,
    parameter int width_o     = 8,
    parameter int width_shift = 5,
    parameter int block_size  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic signed [width_i-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic signed [width_o-1:0] o_data,
    output logic [width_shift-1:0]    o_shift,
    output logic                      o_valid,
    output logic                      o_last,
    input  logic                      i_ready
);

    localparam int IW = $clog2(block_size);
    localparam int MW = $clog2(width_i + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(block_size - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [MW-1:0] MR_ONE   = MW'(1);
    localparam logic [MW-1:0] MR_OUT   = MW'(width_o);
    localparam logic [width_shift-1:0] SH_ONE = width_shift'(1);
    localparam logic signed [width_i:0] ONE_E   = {{width_i{1'b0}}, 1'b1};
    localparam logic signed [width_i:0] SAT_MAX = {{(width_i-width_o+2){1'b0}}, {(width_o-1){1'b1}}};
    localparam logic signed [width_i:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

    // Smallest signed width that can hold x. A negative x needs the same
    // width as ~x, so both cases reduce to finding the top set bit of a
    // non-negative value.
    function automatic logic [MW-1:0] sig_bits(input logic [width_i-1:0] x);
        logic [width_i-1:0] y;
        logic [MW-1:0]      n;
        if (x[width_i-1]) begin
            y = ~x;
        end else begin
            y = x;
        end
        n = MR_ONE;
        for (int i = 0; i < width_i; i++) begin
            if (y[i]) begin
                n = MW'(i + 2);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Shared shift: the bits by which the widest element exceeds width_o.
    function automatic logic [width_shift-1:0] calc_shift(input logic [MW-1:0] m);
        if (m > MR_OUT) begin
            return width_shift'(m - MR_OUT);
        end else begin
            return '0;
        end
    endfunction

    // Arithmetic right shift with round-half-to-even, then saturate to width_o.
    // The floor quotient is kept one bit wider so that a positive tie rounding
    // up past the top of the range saturates instead of wrapping.
    function automatic logic signed [width_o-1:0] rne_sat(
        input logic signed [width_i-1:0] x,
        input logic [width_shift-1:0]    sh
    );
        logic signed [width_i:0] xe;
        logic signed [width_i:0] q;
        logic [width_i-1:0]      rem;
        logic [width_i-1:0]      half;
        logic signed [width_o-1:0] res;
        xe  = {x[width_i-1], x};
        q   = xe >>> sh;
        rem = x & ~({width_i{1'b1}} << sh);
        if (sh == '0) begin
            half = '0;
        end else begin
            half = {{(width_i-1){1'b0}}, 1'b1} << (sh - SH_ONE);
        end
        if ((sh != '0) && ((rem > half) || ((rem == half) && q[0]))) begin
            q = q + ONE_E;
        end else begin
            q = q;
        end
        if (q > SAT_MAX) begin
            res = SAT_MAX[width_o-1:0];
        end else if (q < SAT_MIN) begin
            res = SAT_MIN[width_o-1:0];
        end else begin
            res = q[width_o-1:0];
        end
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [MW-1:0]            max_r_q, max_r_d;
    logic [width_shift-1:0]   shift_q, shift_d;
    logic                     ready_q, ready_d;
    logic signed [width_i-1:0] buf_q [block_size];

    logic                     in_hs_s;
    logic                     out_hs_s;
    logic [MW-1:0]            cur_r_s;
    logic [MW-1:0]            max_upd_s;

    // Next-state logic for the fill/emit controller.
    always_comb begin
        in_hs_s   = i_valid && ready_q && (state_q == FILL);
        out_hs_s  = (state_q == EMIT) && i_ready;
        cur_r_s   = sig_bits(i_data);
        max_upd_s = (cur_r_s > max_r_q) ? cur_r_s : max_r_q;
        state_d   = state_q;
        idx_d     = idx_q;
        max_r_d   = max_r_q;
        shift_d   = shift_q;
        case (state_q)
            FILL: begin
                if (in_hs_s) begin
                    max_r_d = max_upd_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = EMIT;
                        idx_d   = '0;
                        shift_d = calc_shift(max_upd_s);
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            EMIT: begin
                if (out_hs_s) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = FILL;
                        idx_d   = '0;
                        max_r_d = MR_ONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
                max_r_d = MR_ONE;
                shift_d = '0;
            end
        endcase
        // Held low through reset, so o_ready rises on the first edge after release.
        ready_d = (state_d == FILL);
    end

    // Controller state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            max_r_q <= MR_ONE;
            shift_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            max_r_q <= max_r_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
        end
    end

    // Element buffer. It has no reset, because a partial block is discarded
    // by returning idx to 0.
    always_ff @(posedge i_clk) begin
        if (in_hs_s) begin
            buf_q[idx_q] <= i_data;
        end
    end

    // Outputs are derived only from registered state and read 0 outside EMIT.
    always_comb begin
        o_ready = ready_q;
        if (state_q == EMIT) begin
            o_valid = 1'b1;
            o_last  = (idx_q == IDX_LAST);
            o_shift = shift_q;
            o_data  = rne_sat(buf_q[idx_q], shift_q);
        end else begin
            o_valid = 1'b0;
            o_last  = 1'b0;
            o_shift = '0;
            o_data  = '0;
        end
    end

endmodule
